// File: rtl/barrier_scheduler_if.sv
// Spawn offer channel between the barrier scheduler and the playfield.
// The scheduler drives the offer; the playfield answers with ready.
interface barrier_scheduler_if #(
  parameter int unsigned LANE_W = 3
) ();

  logic              spawn_valid;
  logic [LANE_W-1:0] spawn_lane;
  logic              spawn_ready;

  modport master (
    output spawn_valid,
    output spawn_lane,
    input  spawn_ready
  );

  modport slave (
    input  spawn_valid,
    input  spawn_lane,
    output spawn_ready
  );

endinterface

// File: rtl/barrier_scheduler.sv
// Barrier spawn sequencer: spaces spawns by scroll ticks, picks a lane that avoids
// repeating the previous one, and ramps difficulty as spawns are accepted.
module barrier_scheduler #(
  parameter int unsigned LANES      = 8,
  parameter int unsigned LANE_W     = 3,
  parameter int unsigned BASE_GAP   = 8,
  parameter int unsigned MIN_GAP    = 3,
  parameter int unsigned LEVEL_STEP = 16,
  parameter int unsigned MAX_LEVEL  = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                run,
  input  logic                tick,
  input  logic [9:0]          rnd,
  barrier_scheduler_if.master spawn,
  output logic [1:0]          level
);

  localparam int unsigned CntW = (LEVEL_STEP > 1) ? $clog2(LEVEL_STEP) : 1;

  typedef enum logic [1:0] {
    StIdle,
    StWaitGap,
    StPick,
    StOffer
  } state_e;

  state_e            state_q;
  logic              valid_q;
  logic [LANE_W-1:0] lane_q;
  logic [LANE_W-1:0] last_lane_q;
  logic [1:0]        level_q;
  logic [CntW-1:0]   cnt_q;
  logic [4:0]        gap_q;

  logic              hs;
  logic              cnt_wrap;
  logic [1:0]        level_nxt;
  logic [CntW-1:0]   cnt_nxt;
  logic [LANE_W-1:0] cand;
  logic [LANE_W-1:0] pick_lane;

  // Only the gap offset and lane candidate bits of the LFSR word are consumed.
  logic unused_rnd;
  assign unused_rnd = ^rnd[6:3];

  // Gap reload; an underflow or a result below the floor yields MIN_GAP.
  function automatic logic [4:0] gap_for(input logic [2:0] r, input logic [1:0] lvl);
    logic [5:0] sum;
    logic [5:0] sub;
    sum = 6'(BASE_GAP) + {3'b000, r};
    sub = {3'b000, lvl, 1'b0};
    if ((sum < sub) || ((sum - sub) < 6'(MIN_GAP))) begin
      return 5'(MIN_GAP);
    end
    return 5'(sum - sub);
  endfunction

  always_comb begin
    hs        = (state_q == StOffer) && valid_q && spawn.spawn_ready;
    cnt_wrap  = (cnt_q == CntW'(LEVEL_STEP - 1));
    cnt_nxt   = cnt_wrap ? '0 : cnt_q + CntW'(1);
    level_nxt = level_q;
    if (cnt_wrap && (level_q != 2'(MAX_LEVEL))) begin
      level_nxt = level_q + 2'd1;
    end
    cand      = rnd[9 -: LANE_W];
    pick_lane = (cand == last_lane_q) ? LANE_W'((32'(cand) + 32'd1) % LANES) : cand;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= StIdle;
      valid_q     <= 1'b0;
      lane_q      <= '0;
      last_lane_q <= '0;
      level_q     <= 2'd0;
      cnt_q       <= '0;
      gap_q       <= 5'd0;
    end else if (hs) begin
      // An accepted offer always completes, even when run drops on the same edge.
      valid_q     <= 1'b0;
      last_lane_q <= lane_q;
      cnt_q       <= cnt_nxt;
      level_q     <= level_nxt;
      gap_q       <= gap_for(rnd[2:0], level_nxt);
      state_q     <= run ? StWaitGap : StIdle;
    end else if (!run) begin
      state_q <= StIdle;
      valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          valid_q <= 1'b0;
          gap_q   <= gap_for(rnd[2:0], level_q);
          state_q <= StWaitGap;
        end
        StWaitGap: begin
          if (tick) begin
            gap_q <= gap_q - 5'd1;
            if (gap_q <= 5'd1) begin
              state_q <= StPick;
            end
          end
        end
        StPick: begin
          lane_q  <= pick_lane;
          valid_q <= 1'b1;
          state_q <= StOffer;
        end
        StOffer: begin
          // Hold the offer; ticks here are dropped, not banked.
          valid_q <= 1'b1;
        end
        default: begin
          state_q <= StIdle;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign spawn.spawn_valid = valid_q;
  assign spawn.spawn_lane  = lane_q;
  assign level             = level_q;

endmodule

// File: tb/tb_barrier_scheduler.sv
// Directed bench for barrier_scheduler with a lane scoreboard and a small reference model
// of gap, lane choice and level progression.
module tb_barrier_scheduler;

  logic       clk;
  logic       reset;
  logic       run;
  logic       tick;
  logic [9:0] rnd;
  logic [1:0] level;

  barrier_scheduler_if #(.LANE_W(3)) sp ();

  barrier_scheduler dut (
    .clk   (clk),
    .reset (reset),
    .run   (run),
    .tick  (tick),
    .rnd   (rnd),
    .spawn (sp),
    .level (level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model state
  int         m_last;
  int         m_cnt;
  int         m_level;
  int         m_gap;
  int         m_offer_lane;
  int         hs_total;
  logic [2:0] lane_sb[$];

  function automatic int gapf(input logic [9:0] r, input int lvl);
    int g;
    g = 8 + int'(r[2:0]) - 2 * lvl;
    return (g < 3) ? 3 : g;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_last   = 0;
    m_cnt    = 0;
    m_level  = 0;
    hs_total = 0;
  endtask

  // From IDLE: raise run and let the gap load with word r.
  task automatic restart(input logic [9:0] r);
    rnd  = r;
    run  = 1'b1;
    tick = 1'b0;
    step();
    m_gap = gapf(r, m_level);
  endtask

  // From WAIT_GAP with a fresh gap: tick every cycle until the offer appears.
  task automatic reach_offer(input logic [9:0] r, input int exp_lane);
    int         edges;
    logic [2:0] cand;
    logic [2:0] lane;
    rnd  = r;
    tick = 1'b1;
    cand = r[9:7];
    lane = (int'(cand) == m_last) ? cand + 3'd1 : cand;
    if (exp_lane >= 0) lane = 3'(exp_lane);
    lane_sb.push_back(lane);
    edges = 0;
    while (!sp.spawn_valid && edges < 64) begin
      step();
      edges++;
    end
    check("gap_edges", edges, m_gap + 1);
    if (sp.spawn_valid && lane_sb.size() > 0) begin
      m_offer_lane = int'(lane_sb[0]);
      check("spawn_lane", sp.spawn_lane, lane_sb.pop_front());
    end
  endtask

  // Accept the pending offer; stop drops run on the same edge.
  task automatic handshake(input logic [9:0] r_next, input bit stop);
    rnd            = r_next;
    sp.spawn_ready = 1'b1;
    run            = !stop;
    step();
    sp.spawn_ready = 1'b0;
    m_last = m_offer_lane;
    hs_total++;
    m_cnt++;
    if (m_cnt == 16) begin
      m_cnt = 0;
      if (m_level < 3) m_level++;
    end
    m_gap = gapf(r_next, m_level);
    check("valid_after_hs", sp.spawn_valid, 1'b0);
    check("level_after_hs", level, m_level);
  endtask

  initial begin
    logic [9:0] r1;
    logic [9:0] r2;
    reset          = 1'b0;
    run            = 1'b0;
    tick           = 1'b0;
    rnd            = 10'd0;
    sp.spawn_ready = 1'b0;
    model_reset();
    m_offer_lane = 0;
    step();
    step();
    check("rst_valid", sp.spawn_valid, 1'b0);
    check("rst_lane", sp.spawn_lane, 3'd0);
    check("rst_level", level, 2'd0);
    reset = 1'b1;

    // Basic spawn: gap 12, lane bumped from 0 to 1
    restart(10'b0000000100);
    reach_offer(10'b0000000100, 1);

    // Backpressure: offer held, ticks not banked
    for (int i = 0; i < 5; i++) begin
      tick = 1'b1;
      step();
      check("bp_valid", sp.spawn_valid, 1'b1);
      check("bp_lane", sp.spawn_lane, 3'd1);
    end
    handshake(10'b0000000100, 1'b0);
    reach_offer(10'b0000000100, -1);
    handshake(10'($urandom_range(0, 1023)), 1'b0);

    // Level ramp to saturation; last reload at level 3 with rnd[2:0]=0
    while (hs_total < 64) begin
      r1 = 10'($urandom_range(0, 1023));
      r2 = 10'($urandom_range(0, 1023));
      if (hs_total == 63) r2[2:0] = 3'd0;
      reach_offer(r1, -1);
      handshake(r2, 1'b0);
      if (hs_total == 16) check("level_16", level, 2'd1);
      if (hs_total == 48) check("level_48", level, 2'd3);
      if (hs_total == 64) check("level_64", level, 2'd3);
    end
    reach_offer(10'b0000000000 | 10'($urandom_range(0, 1023)), -1);
    handshake(10'b0000000111, 1'b0);

    // Lane wrap
    if (m_last != 7) begin
      reach_offer(10'b1110000000, 7);
      handshake(10'b0000000111, 1'b0);
    end
    reach_offer(10'b1110000000, 0);
    handshake(10'b0000000111, 1'b0);
    reach_offer(10'b1110000000, 7);
    handshake(10'b0000000111, 1'b0);
    reach_offer(10'b1010000000, 5);
    handshake(10'b0000000111, 1'b0);

    // Stop mid-wait: offer stays down, level kept, full gap reloaded on restart
    tick = 1'b1;
    step();
    step();
    run = 1'b0;
    step();
    check("stop_valid", sp.spawn_valid, 1'b0);
    check("stop_level", level, 2'd3);
    for (int i = 0; i < 20; i++) step();
    check("idle_valid", sp.spawn_valid, 1'b0);
    restart(10'b0000000110);
    reach_offer(10'b0110000000, -1);
    handshake(10'b0000000000, 1'b0);

    // Plain reset, then climb to the 32nd handshake, which coincides with run dropping
    reset = 1'b0;
    step();
    check("rst2_level", level, 2'd0);
    reset = 1'b1;
    model_reset();
    restart(10'b0000000000);
    while (hs_total < 31) begin
      reach_offer(10'($urandom_range(0, 1023)), -1);
      handshake(10'($urandom_range(0, 1023)), 1'b0);
    end
    reach_offer(10'b0100000001, -1);
    handshake(10'b0000000001, 1'b1);
    check("stop_hs_level", level, 2'd2);
    tick = 1'b1;
    for (int i = 0; i < 20; i++) step();
    check("stop_hs_idle", sp.spawn_valid, 1'b0);
    // Candidate equals the lane just accepted, so it must be bumped
    restart(10'b0000000010);
    reach_offer(10'(m_last << 7), (m_last + 1) % 8);

    // Reset while offering at level 2
    reset = 1'b0;
    step();
    check("rst_offer_valid", sp.spawn_valid, 1'b0);
    check("rst_offer_level", level, 2'd0);
    check("rst_offer_lane", sp.spawn_lane, 3'd0);
    reset = 1'b1;
    model_reset();
    restart(10'b0000000100);
    reach_offer(10'b0000000100, 1);
    handshake(10'b0000000100, 1'b0);
    check("sb_empty", lane_sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
